fetch_icache_nway: RTL
======================

// Module: fetch_icache_nway
// PURPOSE
//  Parametrised N-way set-associative instruction cache for the IF stage. It replaces the
//  single-line fetch memory: lookup is combinational, misses run a blocking line refill over
//  a req/valid memory handshake, victims are chosen by LRU, and a flush input clears the cache.
//  Sits between the PC register and the instruction memory; stall feeds the pipeline hazard unit.
// PARAMETERS
//  ADDR_W      32   byte address width
//  WORD_W      32   instruction width
//  LINE_WORDS  4    words per line (power of 2); mem_in width = WORD_W*LINE_WORDS
//  SETS        8    sets (power of 2)
//  WAYS        2    associativity, 1 or 2; 1 = direct-mapped, LRU logic removed
// PORTS
//  clk          in   1                  clock, rising edge
//  rst          in   1                  reset, asynchronous, active-low
//  req_valid    in   1                  fetch request valid this cycle
//  address      in   ADDR_W             byte address of the instruction
//  flush        in   1                  invalidate all lines
//  instruction  out  WORD_W             fetched word; 0 when hit=0
//  hit          out  1                  req_valid & tag match in IDLE (combinational)
//  stall        out  1                  (req_valid & ~hit) | (state!=IDLE)
//  mem_req      out  1                  line refill request (registered)
//  mem_addr     out  ADDR_W             line-aligned refill address (registered)
//  mem_valid    in   1                  refill data valid (one-cycle pulse)
//  mem_in       in   WORD_W*LINE_WORDS  refill line; word k = mem_in[k*WORD_W +: WORD_W]
// BEHAVIOUR
//  - Address split: [1:0] byte (ignored) | word offset log2(LINE_WORDS) | index log2(SETS) | tag.
//  - Reset (rst=0, async): all valid bits=0, LRU bits=0, state=IDLE, mem_req=0, mem_addr=0.
//    Outputs are then hit=0, instruction=0, stall=req_valid. Data/tag arrays are not cleared.
//  - FSM IDLE:
//    - Hit: 0-cycle latency; instruction = selected word; the set's LRU points to the other way.
//    - req_valid & miss: at the next edge latch the line address, assert mem_req, go to MISS.
//  - FSM MISS: mem_req=1 and mem_addr are held stable; address and req_valid changes are ignored.
//    - On the edge where mem_valid=1: write the line, tag and valid=1 into the victim way;
//      LRU points away from the victim; mem_req=0; go to IDLE.
//    - The next cycle re-looks-up the current address (hit if it is unchanged).
//  - Miss cost: 2 cycles minimum (request, then a mem_valid in the following cycle); hit on the third.
//  - Victim choice: the first invalid way (way0 before way1), otherwise the way the set's LRU
//    bit points to. With WAYS=1 the victim is always way0.
//  - mem_valid while in IDLE is ignored.
//  - flush: all valid bits are cleared at the edge and hit is forced 0 in that cycle.
//    - In IDLE, flush has priority over starting a miss (the miss starts the next cycle).
//    - In MISS, the pending refill still completes and installs its line.
//  - Hit and flush in the same cycle: hit=0, stall=1.
//  - Reset mid-MISS: the refill is aborted; a late mem_valid arrives in IDLE and is ignored.
//  - Tag compare uses the full tag width. No partial-line or critical-word-first support.
// STRUCTURE
//  - Shared package fetch_pkg:
//    - state encoding IC_IDLE=0, IC_MISS=1;
//    - localparam helpers OFF_W=$clog2(LINE_WORDS), IDX_W=$clog2(SETS), TAG_W=ADDR_W-2-OFF_W-IDX_W.
//  - Sub-module icache_way, instantiated WAYS times:
//    - per-set tag/valid/line storage;
//    - combinational match plus word select;
//    - write port and global valid clear.
//  - The top level holds the FSM, LRU bits, victim select and output mux.
// TESTING (defaults, 2-way; line L = 128'hFFFFFFFF_00000000_FFFFFFFF_00007C00)
//  1. Reset, then req address=0x8 -> hit=0, stall=1; next cycle mem_req=1, mem_addr=0x0;
//     pulse mem_valid with L -> next cycle hit=1, instruction=0x00000000, stall=0.
//  2. Then address=0x0 / 0x4 / 0xC -> same cycle hit=1 with 0x00007C00 / 0xFFFFFFFF /
//     0xFFFFFFFF, mem_req stays 0.
//  3. Fill 0x000 and 0x080 (same set 0); touch 0x000; miss on 0x100 -> the 0x080 way is replaced.
//     Then 0x000 hits and 0x080 misses.
//  4. Assert flush for 1 cycle after test 2 -> address 0x0 hit=0 and a refill is requested at 0x0.
//  5. Drop rst during MISS -> mem_req=0 immediately; mem_valid 2 cycles later is ignored, hit stays 0.
//  6. Change address to 0x40 during MISS -> mem_addr stays 0x0; after the fill, a new miss
//     starts with mem_addr=0x40.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the IF-stage instruction cache: the refill FSM
//   state encoding, the default cache geometry, and helpers that derive the
//   address field widths (word offset, set index, tag) from that geometry.
//   No ports; imported by fetch_icache_nway and icache_way.
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic {
    IC_IDLE = 1'b0,
    IC_MISS = 1'b1
  } ic_state_t;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_WORD_W     = 32;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_SETS       = 8;
  localparam int DEF_WAYS       = 2;

  localparam int OFF_W = $clog2(DEF_LINE_WORDS);
  localparam int IDX_W = $clog2(DEF_SETS);
  localparam int TAG_W = DEF_ADDR_W - 2 - OFF_W - IDX_W;

  // The byte offset inside a word is always two bits wide, so whatever is
  // left above the word offset and set index is the tag.
  function automatic int calc_tag_w(input int addr_w, input int line_words, input int sets);
    return addr_w - 2 - $clog2(line_words) - $clog2(sets);
  endfunction

endpackage

// File: rtl/icache_way.sv
// ---------------------------------------------------------------------------
// icache_way
//   One way of the set-associative instruction cache. Holds a valid bit, a
//   tag and a full line for every set. Lookup is purely combinational; the
//   single write port installs a whole line with its tag and sets the valid
//   bit. clear_all drops every valid bit at once (cache flush).
// Ports
//   clk, rst         clock (rising edge) / async active-low reset of valid bits
//   rd_idx, rd_tag   set index and tag of the current fetch address
//   rd_off           word offset inside the line for the fetched word
//   match            set is valid and its tag equals rd_tag
//   word             word rd_off of the line stored at rd_idx
//   wr_en            install wr_line / wr_tag into set wr_idx
//   wr_idx, wr_tag   target set and tag of the refill
//   wr_line          refill line, word k at [k*WORD_W +: WORD_W]
//   clear_all        invalidate all sets
//   fill_valid       valid bit of set wr_idx (used for victim choice)
// ---------------------------------------------------------------------------
module icache_way
  import fetch_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int SETS       = DEF_SETS,
  parameter int OFF_BITS   = OFF_W,
  parameter int IDX_BITS   = IDX_W,
  parameter int TAG_BITS   = TAG_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IDX_BITS-1:0]          rd_idx,
  input  logic [TAG_BITS-1:0]          rd_tag,
  input  logic [OFF_BITS-1:0]          rd_off,
  output logic                         match,
  output logic [WORD_W-1:0]            word,
  input  logic                         wr_en,
  input  logic [IDX_BITS-1:0]          wr_idx,
  input  logic [TAG_BITS-1:0]          wr_tag,
  input  logic [WORD_W*LINE_WORDS-1:0] wr_line,
  input  logic                         clear_all,
  output logic                         fill_valid
);

  logic [SETS-1:0]              valid_q;
  logic [TAG_BITS-1:0]          tag_q  [SETS];
  logic [WORD_W*LINE_WORDS-1:0] line_q [SETS];
  logic [WORD_W-1:0]            line_words [LINE_WORDS];

  // Valid bits are the only state that must come out of reset clean. A
  // refill landing on the same edge as a flush still installs its line,
  // so the write is applied after the global clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      if (clear_all) begin
        valid_q <= '0;
      end
      if (wr_en) begin
        valid_q[wr_idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset; a line is only ever read when
  // its valid bit is set, which guarantees it was written first.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      line_q[wr_idx] <= wr_line;
    end
  end

  // Break the selected line into words so the offset can pick one
  // directly instead of computing a bit position.
  always_comb begin
    for (int k = 0; k < LINE_WORDS; k++) begin
      line_words[k] = line_q[rd_idx][k*WORD_W +: WORD_W];
    end
  end

  assign match      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign word       = line_words[rd_off];
  assign fill_valid = valid_q[wr_idx];

endmodule

// File: rtl/fetch_icache_nway.sv
// ---------------------------------------------------------------------------
// fetch_icache_nway
//   N-way (1 or 2) set-associative instruction cache for the IF stage.
//   Hits return the word in the same cycle. A miss latches the line address
//   and runs a blocking refill over a req/valid handshake; the refilled line
//   goes into the first invalid way, otherwise into the least recently used
//   way. flush invalidates the whole cache.
// Ports
//   clk, rst     clock (rising edge) / async active-low reset
//   req_valid    fetch request this cycle
//   address      byte address of the instruction
//   flush        invalidate all lines
//   instruction  fetched word, 0 when hit is low
//   hit          combinational hit (only in IDLE, never during flush)
//   stall        request not served this cycle, or refill in progress
//   mem_req      registered refill request, held until mem_valid
//   mem_addr     registered line-aligned refill address
//   mem_valid    one-cycle pulse carrying the refill line
//   mem_in       refill line, word k at [k*WORD_W +: WORD_W]
// ---------------------------------------------------------------------------
module fetch_icache_nway
  import fetch_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int WORD_W     = DEF_WORD_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int SETS       = DEF_SETS,
  parameter int WAYS       = DEF_WAYS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  input  logic [ADDR_W-1:0]            address,
  input  logic                         flush,
  output logic [WORD_W-1:0]            instruction,
  output logic                         hit,
  output logic                         stall,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic                         mem_valid,
  input  logic [WORD_W*LINE_WORDS-1:0] mem_in
);

  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_BITS = calc_tag_w(ADDR_W, LINE_WORDS, SETS);
  localparam int LINE_LSB = 2 + OFF_BITS;

  ic_state_t             state_q;
  ic_state_t             state_d;
  logic [OFF_BITS-1:0]   rd_off;
  logic [IDX_BITS-1:0]   rd_idx;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [IDX_BITS-1:0]   fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;
  logic [WAYS-1:0]       way_match;
  logic [WAYS-1:0]       way_fill_valid;
  logic [WAYS-1:0]       way_wr;
  logic [WORD_W-1:0]     way_word [WAYS];
  logic [WORD_W-1:0]     hit_word;
  logic                  fill_now;
  logic                  start_miss;
  logic                  victim;
  logic [1:0]            unused_byte_sel;

  assign unused_byte_sel = address[1:0];

  assign rd_off   = address[LINE_LSB-1:2];
  assign rd_idx   = address[LINE_LSB +: IDX_BITS];
  assign rd_tag   = address[ADDR_W-1 -: TAG_BITS];
  assign fill_idx = mem_addr[LINE_LSB +: IDX_BITS];
  assign fill_tag = mem_addr[ADDR_W-1 -: TAG_BITS];

  assign fill_now = (state_q == IC_MISS) && mem_valid;

  // Every way sees the same lookup and the same refill line; only the
  // victim way gets the write enable.
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .WORD_W     (WORD_W),
      .LINE_WORDS (LINE_WORDS),
      .SETS       (SETS),
      .OFF_BITS   (OFF_BITS),
      .IDX_BITS   (IDX_BITS),
      .TAG_BITS   (TAG_BITS)
    ) u_way (
      .clk        (clk),
      .rst        (rst),
      .rd_idx     (rd_idx),
      .rd_tag     (rd_tag),
      .rd_off     (rd_off),
      .match      (way_match[w]),
      .word       (way_word[w]),
      .wr_en      (way_wr[w]),
      .wr_idx     (fill_idx),
      .wr_tag     (fill_tag),
      .wr_line    (mem_in),
      .clear_all  (flush),
      .fill_valid (way_fill_valid[w])
    );

    assign way_wr[w] = fill_now && (victim == 1'(w));
  end

  if (WAYS == 2) begin : g_lru
    logic [SETS-1:0] lru_q;

    // Victim for the pending refill: an empty way is always preferred,
    // way0 first; with both ways full the set's LRU bit decides.
    always_comb begin
      if (!way_fill_valid[0]) begin
        victim = 1'b0;
      end else if (!way_fill_valid[1]) begin
        victim = 1'b1;
      end else begin
        victim = lru_q[fill_idx];
      end
    end

    // The LRU bit names the way to evict next, so any access (hit or
    // refill) makes it point at the other way of that set.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lru_q <= '0;
      end else if (fill_now) begin
        lru_q[fill_idx] <= ~victim;
      end else if (hit) begin
        lru_q[rd_idx] <= ~way_match[1];
      end
    end
  end else begin : g_direct
    assign victim = 1'b0;
  end

  // At most one way can match a given tag, so OR-ing the matching way's
  // word is enough to select it.
  always_comb begin
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_match[w]) begin
        hit_word = way_word[w];
      end
    end
  end

  // State register of the refill FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and fetch-side outputs. Lookups only count in IDLE, and a
  // flush both hides the hit and postpones any miss to the next cycle.
  // While a refill is outstanding the fetch address is ignored.
  always_comb begin
    state_d     = state_q;
    hit         = 1'b0;
    stall       = 1'b0;
    instruction = '0;
    start_miss  = 1'b0;
    case (state_q)
      IC_IDLE: begin
        hit         = req_valid && !flush && (|way_match);
        instruction = hit ? hit_word : '0;
        stall       = req_valid && !hit;
        if (req_valid && !hit && !flush) begin
          start_miss = 1'b1;
          state_d    = IC_MISS;
        end
      end
      IC_MISS: begin
        stall = 1'b1;
        if (mem_valid) begin
          state_d = IC_IDLE;
        end
      end
      default: begin
        state_d = IC_IDLE;
      end
    endcase
  end

  // Refill request towards memory. The line address is captured when the
  // miss starts and held untouched until the line arrives, so memory sees
  // a stable request regardless of what the PC does meanwhile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else if (start_miss) begin
      mem_req  <= 1'b1;
      mem_addr <= {address[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
    end else if (fill_now) begin
      mem_req  <= 1'b0;
    end
  end

endmodule
